// File: rtl/brq_dmem_ctrl_if.sv
// Request/response bus between the load/store stage (master) and the
// data-memory controller (slave).
`timescale 1ns/1ps
interface brq_dmem_ctrl_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 15
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [2:0]           req_byte_en;
  logic                 req_unsigned;
  logic [AddrWidth-1:0] req_addr;
  logic [DataWidth-1:0] req_wdata;
  logic                 resp_valid;
  logic [DataWidth-1:0] resp_rdata;
  logic                 resp_err;
  logic                 busy;

  modport master (
    output req_valid, req_we, req_byte_en, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_byte_en, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err, busy
  );
endinterface

// File: rtl/brq_dmem_ctrl.sv
// Data-memory controller: one request at a time against a single-port SRAM,
// sub-word stores as read-modify-write. Define DMEM_ERR_EN to flag lane code 111.
`timescale 1ns/1ps
module brq_dmem_ctrl #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 15
) (
  input  logic                 brq_clk,
  input  logic                 brq_rst_n,
  brq_dmem_ctrl_if.slave       bus,
  output logic                 sram_csb,
  output logic                 sram_web,
  output logic [AddrWidth-1:0] sram_addr,
  output logic [DataWidth-1:0] sram_din,
  input  logic [DataWidth-1:0] sram_dout
);

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

  state_t               state, state_next;
  logic                 we_q;
  logic                 uns_q;
  logic                 word_q;
  logic [2:0]           be_q;
  logic [AddrWidth-1:0] addr_q;
  logic [DataWidth-1:0] wdata_q;
  logic [DataWidth-1:0] rdata_q;
  logic [DataWidth-1:0] merge_q;
  logic                 accept;
  logic                 is_err_req;
  logic                 is_word_req;
  logic [7:0]           lane_byte;
  logic [15:0]          lane_half;
  logic [DataWidth-1:0] load_val;
  logic [DataWidth-1:0] merge_val;

  // Without the error feature, lane code 111 falls through to a word access.
  always_comb begin
    is_err_req = 1'b0;
`ifdef DMEM_ERR_EN
    is_err_req = (bus.req_byte_en == 3'b111);
`endif
    is_word_req = (bus.req_byte_en == 3'b110) ||
                  ((bus.req_byte_en == 3'b111) && !is_err_req);
    accept      = (state == IDLE) && bus.req_valid;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (bus.req_valid) begin
          if (is_err_req)                      state_next = RESP;
          else if (bus.req_we && is_word_req)  state_next = WR;
          else                                 state_next = RD;
        end
      end
      RD:      state_next = CAP;
      CAP:     state_next = we_q ? WR : RESP;
      WR:      state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Lane extraction from the word read back in CAP.
  always_comb begin
    lane_byte = sram_dout[7:0];
    case (be_q[1:0])
      2'd0:    lane_byte = sram_dout[7:0];
      2'd1:    lane_byte = sram_dout[15:8];
      2'd2:    lane_byte = sram_dout[23:16];
      default: lane_byte = sram_dout[31:24];
    endcase
    lane_half = be_q[0] ? sram_dout[31:16] : sram_dout[15:0];
    case (be_q)
      3'b000, 3'b001, 3'b010, 3'b011:
        load_val = {{24{lane_byte[7] & ~uns_q}}, lane_byte};
      3'b100, 3'b101:
        load_val = {{16{lane_half[15] & ~uns_q}}, lane_half};
      default:
        load_val = sram_dout;
    endcase
  end

  always_comb begin
    merge_val = sram_dout;
    case (be_q)
      3'b000:  merge_val[7:0]   = wdata_q[7:0];
      3'b001:  merge_val[15:8]  = wdata_q[7:0];
      3'b010:  merge_val[23:16] = wdata_q[7:0];
      3'b011:  merge_val[31:24] = wdata_q[7:0];
      3'b100:  merge_val[15:0]  = wdata_q[15:0];
      3'b101:  merge_val[31:16] = wdata_q[15:0];
      default: merge_val        = wdata_q;
    endcase
  end

  // Stores and error responses clear the load result at accept so they report 0.
  always_ff @(posedge brq_clk) begin
    if (!brq_rst_n) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      word_q  <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      merge_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        we_q    <= bus.req_we;
        uns_q   <= bus.req_unsigned;
        word_q  <= is_word_req;
        be_q    <= bus.req_byte_en;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        if (bus.req_we || is_err_req) rdata_q <= '0;
      end
      if (state == CAP) begin
        if (we_q) merge_q <= merge_val;
        else      rdata_q <= load_val;
      end
    end
  end

`ifdef DMEM_ERR_EN
  logic err_q;

  always_ff @(posedge brq_clk) begin
    if (!brq_rst_n)  err_q <= 1'b0;
    else if (accept) err_q <= is_err_req;
  end

  assign bus.resp_err = (state == RESP) && err_q;
`else
  assign bus.resp_err = 1'b0;
`endif

  assign bus.req_ready  = (state == IDLE);
  assign bus.busy       = (state != IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;

  // Reset gates the SRAM strobes directly so an interrupted WR never writes.
  assign sram_csb  = !(brq_rst_n && ((state == RD) || (state == WR)));
  assign sram_web  = !(brq_rst_n && (state == WR));
  assign sram_addr = addr_q;
  assign sram_din  = (state == WR) ? (word_q ? wdata_q : merge_q) : '0;

endmodule

// File: doc/brq_dmem_ctrl.md
Name: brq_dmem_ctrl

Overview:
- Data-memory responder on the memory side of the load/store stage.
- Accepts one load/store request at a time, encoded as word address + 3-bit lane code + signed/unsigned flag.
- Drives a single-port synchronous SRAM macro. Sub-word stores are done as read-modify-write.
- Returns sign- or zero-extended load data, and holds the core stalled through a busy flag while a request is in flight.

Parameters:
- DataWidth, 32, data bus width; logic is defined for 32 only.
- AddrWidth, 15, word-address width of the SRAM.

Ports:
- brq_clk  in  1  clock.
- brq_rst_n  in  1  synchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_byte_en  in  3  lane code: 000–011 = byte lane 0–3; 100 = half [15:0]; 101 = half [31:16]; 110 = word; 111 = illegal.
- req_unsigned  in  1  zero-extend load (lbu/lhu).
- req_addr  in  AddrWidth  word address.
- req_wdata  in  DataWidth  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  DataWidth  extended load data; 0 for stores.
- resp_err  out  1  illegal request (optional feature only).
- busy  out  1  FSM not in IDLE; drives core stall.
- sram_csb  out  1  chip select, active low.
- sram_web  out  1  write enable, active low.
- sram_addr  out  AddrWidth  SRAM address.
- sram_din  out  DataWidth  SRAM write data.
- sram_dout  in  DataWidth  SRAM read data, valid the cycle after the read cycle.

Behaviour:
- Reset:
  - brq_rst_n low at a rising edge forces state IDLE.
  - Clears all request and data registers.
  - Outputs after reset: resp_valid=0, resp_rdata=0, resp_err=0, busy=0, sram_csb=1, sram_web=1, sram_addr=0, sram_din=0.
  - sram_csb and sram_web are gated to 1 combinationally while brq_rst_n=0, so a reset mid-operation, even in WR, never writes the SRAM.
- States: IDLE, RD, CAP, WR, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, latch all req_* fields.
  - Next state: word store (byte_en=110, we=1) goes to WR; everything else goes to RD.
- RD:
  - sram_csb=0, sram_web=1, sram_addr=latched addr.
  - Next state: CAP.
- CAP:
  - sram_dout is valid.
  - Load: register the extracted and extended value. Next state RESP.
  - Sub-word store: register the merge word, which is sram_dout with only the selected lane(s) replaced by the low 8/16 bits of wdata. Next state WR.
- WR:
  - sram_csb=0, sram_web=0.
  - sram_din = wdata for a word store, merge word for a sub-word store.
  - Next state: RESP.
- RESP:
  - resp_valid=1 for exactly one cycle.
  - Next state: IDLE.
- Latency, counted with the accept cycle as cycle 0; resp_valid rises in:
  - load: cycle 3;
  - word store: cycle 2;
  - sub-word store: cycle 4.
- Control signals:
  - busy=1 in every state except IDLE.
  - req_ready=0 whenever busy=1; the requester holds its request and no request is accepted in RESP.
  - sram_csb=1 and sram_web=1 in IDLE, CAP and RESP.
- Load extraction:
  - Byte lane n takes bits [8n+7:8n].
  - Half 100 takes [15:0]; half 101 takes [31:16]; word takes all 32 bits.
  - Signed loads replicate the MSB of the extracted field; req_unsigned=1 fills with zeros.
  - req_unsigned is ignored for word loads and for stores.
- resp_rdata holds its value until the next load's CAP; for a store it is 0 at resp_valid.
- req_byte_en=111 without the optional feature: treated as a word access.

Optional Feature:
- Macro: DMEM_ERR_EN.
- Defined:
  - req_byte_en=111 is accepted and goes IDLE → RESP with no SRAM access.
  - resp_valid=1 and resp_err=1 together; resp_rdata=0.
  - Latency is 1 cycle.
- Undefined:
  - resp_err is tied 0.
  - 111 behaves as 110.

Test Plan:
- Preload word 5 = 0x8899AABB; load 5, byte_en=011, signed → resp_valid in cycle 3, resp_rdata=0xFFFFFF88.
- Same load with req_unsigned=1 → 0x00000088. Load 5, byte_en=101, signed → 0xFFFF8899. Load 5, byte_en=100, unsigned → 0x0000AABB.
- Store byte_en=001, wdata=0x000000CC to word 5 → RD cycle 1, write cycle 3 with sram_din=0x8899CCBB, resp cycle 4; word 5 then reads 0x8899CCBB.
- Store byte_en=110, wdata=0x12345678 to word 7 → no read cycle, write in cycle 1, resp cycle 2, resp_rdata=0.
- Keep req_valid high while busy with a second request → only one accept; the second is accepted in the cycle after resp_valid, with busy=1 from cycle 1 through the response.
- Assert brq_rst_n=0 during WR of a sub-word store → sram_web stays 1 that cycle, memory unchanged, next cycle busy=0 and req_ready=1. With DMEM_ERR_EN, byte_en=111 → resp_valid=1 and resp_err=1 in cycle 1, sram_csb stays 1.
